frame_assembler: RTL and testbench
==================================

# frame_assembler

Parametrised UART frame deframer between the UART receiver and the command/configuration decoder. It rebuilds a nibble-coded frame from the receiver byte stream:
- SOF byte, then sequence-tagged nibble bytes, then EOF byte.
- Supports a configurable frame width, optional exact-length checking and an inter-byte timeout.
- Double-buffers the result behind a valid/accept handshake so the next frame can arrive while the previous one is held.
- Reports each failure class on its own error pulse.

## Interface
Parameters:
- NIBBLES, 40, maximum payload nibbles; frame_data is 4*NIBBLES bits wide (default 160).
- SOF_BYTE, 8'h00, start-of-frame byte.
- EOF_BYTE, 8'h0F, end-of-frame byte.
- LEN_EXACT, 0, 1: EOF is accepted only when exactly NIBBLES nibbles were received; 0: any count from 1 to NIBBLES is accepted.
- TIMEOUT_CYCLES, 1000000, clock cycles without rx_ready inside a frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_ready  in  1  one-cycle strobe; rx_data/rx_parity_error valid.
- rx_parity_error  in  1  parity error flag for the current byte.
- frame_accept  in  1  consumer takes the held frame when high together with frame_ready.
- frame_ready  out  1  output frame valid; held until accepted.
- frame_data  out  4*NIBBLES  assembled payload, right-aligned.
- frame_len  out  $clog2(NIBBLES+1)  number of nibbles in the held frame.
- err_seq, err_parity, err_length, err_timeout, err_overflow  out  1 each  one-cycle error pulses.

## Operation
- Byte classes:
  - SOF_BYTE and EOF_BYTE are control bytes.
  - Every other byte is a nibble byte: tag = rx_data[7:4], payload = rx_data[3:0].
- Expected tag starts at 1, increments per accepted nibble, and wraps 15 -> 1 (0 is never a valid tag).
- States: IDLE, GET_DATA. The output register is independent of the state machine.
- IDLE:
  - On rx_ready with rx_data==SOF_BYTE and no parity error: go to GET_DATA. Clear the shift buffer, nibble count = 0, expected tag = 1, timer = 0.
  - All other bytes are ignored silently.
- GET_DATA, on rx_ready, checks in priority order:
  1. Parity error: pulse err_parity, go to IDLE.
  2. SOF_BYTE: restart. Clear the buffer, count and tag; stay in GET_DATA.
  3. EOF_BYTE, in priority order:
     - count==0, or LEN_EXACT and count!=NIBBLES: pulse err_length, go to IDLE.
     - Output still held and not accepted this cycle: pulse err_overflow, drop the new frame, go to IDLE. The held frame is unchanged.
     - Otherwise: load frame_data = buffer and frame_len = count, set frame_ready, go to IDLE.
  4. Tag matches and count<NIBBLES: buffer = {buffer, payload}, count+1, advance the tag.
  5. Tag matches and count==NIBBLES: pulse err_length, go to IDLE.
  6. Tag mismatch: pulse err_seq, go to IDLE.
- Timeout, in GET_DATA only:
  - The timer clears on every rx_ready and increments on every other cycle.
  - If the timer reaches TIMEOUT_CYCLES-1 and rx_ready is low, the next edge pulses err_timeout and returns to IDLE.
- Payload alignment:
  - The first received nibble is the most significant of the received nibbles.
  - Unused upper bits of frame_data are 0.
- Output handshake:
  - frame_ready & frame_accept clears frame_ready on the next edge; frame_data/frame_len keep their values until the next load.
  - If the accept and a new load occur in the same cycle, the new frame is loaded, frame_ready stays 1, and no overflow is flagged.

## Timing
- Reset values: state IDLE; frame_ready=0, frame_data=0, frame_len=0, all err_*=0; buffer, count, tag=1 and timer cleared.
- A reset mid-frame or while a frame is held discards everything.
- Latency: frame_ready rises on the edge after the EOF rx_ready cycle (1 cycle).
- Every err_* is high for exactly 1 cycle, on the edge after the triggering event. At most one err_* pulses per cycle.
- The block accepts rx_ready on consecutive cycles; no input back-pressure exists.
- frame_accept while frame_ready=0 has no effect.

## Test plan
- NIBBLES=4: bytes 00,1A,2B,3C,4D,0F -> one cycle after 0F: frame_ready=1, frame_data=16'hABCD, frame_len=4. Held for 10 cycles with frame_accept=0; clears one cycle after frame_accept.
- NIBBLES=20, tags 1..F then 1..5, payload 0..F,0..3 -> frame_data=80'h0123456789ABCDEF0123, no err_*. Then with LEN_EXACT=1, frame 00,1A,2B,0F -> err_length pulse, frame_ready stays 0.
- NIBBLES=4: 00,1A,3B -> err_seq one cycle after 3B. The following 4C,0F are ignored (no frame, no error). Then 00,15,0F -> frame_data=16'h0005, frame_len=1.
- Frame held, second frame 00,17,0F with frame_accept=0 -> err_overflow, frame_data unchanged. Repeat with frame_accept=1 in the 0F cycle -> frame_data=16'h0007, frame_ready stays 1, no error.
- TIMEOUT_CYCLES=16: 00,1A, then idle -> err_timeout exactly 16 cycles after the 1A strobe. 00,1A then 2B with rx_parity_error=1 -> err_parity, no frame.
- Reset asserted for 1 cycle between 2B and 0F of a frame, with a frame held -> all outputs 0; the subsequent 0F produces nothing.

Source files
------------

// File: rtl/frame_assembler.sv
// ============================================================================
// frame_assembler
//   Rebuilds an SOF / tagged-nibble / EOF frame from a UART byte stream and
//   holds the result behind a valid/accept handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_assembler #(
    parameter int         NIBBLES        = 40,
    parameter logic [7:0] SOF_BYTE       = 8'h00,
    parameter logic [7:0] EOF_BYTE       = 8'h0F,
    parameter bit         LEN_EXACT      = 1'b0,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_ready,
    input  logic                             rx_parity_error,
    input  logic                             frame_accept,
    output logic                             frame_ready,
    output logic [4*NIBBLES-1:0]             frame_data,
    output logic [$clog2(NIBBLES+1)-1:0]     frame_len,
    output logic                             err_seq,
    output logic                             err_parity,
    output logic                             err_length,
    output logic                             err_timeout,
    output logic                             err_overflow
);

    localparam int DW = 4 * NIBBLES;
    localparam int LW = $clog2(NIBBLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LW-1:0] C_NIB_MAX  = LW'(NIBBLES);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t        state_q;
    logic [DW-1:0] buf_q;
    logic [LW-1:0] cnt_q;
    logic [3:0]    tag_q;
    logic [TW-1:0] timer_q;
    logic          ready_q;
    logic [DW-1:0] data_q;
    logic [LW-1:0] len_q;
    logic          e_seq_q, e_par_q, e_len_q, e_tmo_q, e_ovf_q;

    logic          w_is_sof, w_is_eof, w_tag_ok, w_len_bad, w_held, w_tmo, w_load;
    logic [DW-1:0] w_shift;

    assign w_is_sof  = (rx_data == SOF_BYTE);
    assign w_is_eof  = (rx_data == EOF_BYTE);
    assign w_tag_ok  = (rx_data[7:4] == tag_q);
    assign w_len_bad = (cnt_q == '0) || (LEN_EXACT && (cnt_q != C_NIB_MAX));
    assign w_held    = ready_q && !frame_accept;
    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (timer_q == C_TMO_LAST);
    assign w_shift   = DW'({buf_q, rx_data[3:0]});
    assign w_load    = (state_q == S_DATA) && rx_ready && !rx_parity_error && !w_is_sof
                       && w_is_eof && !w_len_bad && !w_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= 4'd1;
            timer_q <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            e_seq_q <= 1'b0;
            e_par_q <= 1'b0;
            e_len_q <= 1'b0;
            e_tmo_q <= 1'b0;
            e_ovf_q <= 1'b0;
        end else begin
            e_seq_q <= 1'b0;
            e_par_q <= 1'b0;
            e_len_q <= 1'b0;
            e_tmo_q <= 1'b0;
            e_ovf_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (rx_ready && w_is_sof && !rx_parity_error) begin
                        state_q <= S_DATA;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        tag_q   <= 4'd1;
                        timer_q <= '0;
                    end
                end
                default: begin
                    if (rx_ready) begin
                        timer_q <= '0;
                        if (rx_parity_error) begin
                            e_par_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (w_is_sof) begin
                            buf_q <= '0;
                            cnt_q <= '0;
                            tag_q <= 4'd1;
                        end else if (w_is_eof) begin
                            state_q <= S_IDLE;
                            if (w_len_bad)
                                e_len_q <= 1'b1;
                            else if (w_held)
                                e_ovf_q <= 1'b1;
                        end else if (w_tag_ok) begin
                            if (cnt_q != C_NIB_MAX) begin
                                buf_q <= w_shift;
                                cnt_q <= cnt_q + 1'b1;
                                // Tag 0 is reserved, so the sequence wraps 15 -> 1.
                                tag_q <= (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
                            end else begin
                                e_len_q <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            e_seq_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (w_tmo) begin
                        e_tmo_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            endcase

            if (w_load) begin
                ready_q <= 1'b1;
                data_q  <= buf_q;
                len_q   <= cnt_q;
            end else if (ready_q && frame_accept) begin
                ready_q <= 1'b0;
            end
        end
    end

    assign frame_ready  = ready_q;
    assign frame_data   = data_q;
    assign frame_len    = len_q;
    assign err_seq      = e_seq_q;
    assign err_parity   = e_par_q;
    assign err_length   = e_len_q;
    assign err_timeout  = e_tmo_q;
    assign err_overflow = e_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_assembler.sv
// ============================================================================
// tb_frame_assembler
//   Drives two differently parameterised deframers from one byte stream and
//   scores both against a frame-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rx_ready, rx_parity_error, frame_accept;
    logic [7:0] rx_data;

    logic        rdy_a, rdy_b;
    logic [15:0] data_a;
    logic [79:0] data_b;
    logic [2:0]  len_a;
    logic [4:0]  len_b;
    logic [4:0]  err_a, err_b;  // {seq, parity, length, timeout, overflow}

    frame_assembler #(.NIBBLES(4), .LEN_EXACT(1'b0), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_parity_error(rx_parity_error), .frame_accept(frame_accept),
        .frame_ready(rdy_a), .frame_data(data_a), .frame_len(len_a),
        .err_seq(err_a[4]), .err_parity(err_a[3]), .err_length(err_a[2]),
        .err_timeout(err_a[1]), .err_overflow(err_a[0])
    );

    frame_assembler #(.NIBBLES(20), .LEN_EXACT(1'b1), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_parity_error(rx_parity_error), .frame_accept(frame_accept),
        .frame_ready(rdy_b), .frame_data(data_b), .frame_len(len_b),
        .err_seq(err_b[4]), .err_parity(err_b[3]), .err_length(err_b[2]),
        .err_timeout(err_b[1]), .err_overflow(err_b[0])
    );

    typedef struct {
        bit           active;
        int           cnt;
        logic [159:0] acc;
        int           idle;
        bit           held;
        logic [159:0] hdata;
        int           hlen;
    } mdl_t;

    typedef struct {
        logic [4:0]   err;
        bit           rdy;
        logic [159:0] data;
        int           len;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rand_fa = 1'b0;
    mdl_t m_a, m_b;
    exp_t q_a[$], q_b[$];

    function automatic void mdl_step(inout mdl_t m, input int n, input bit lx, input int to,
                                     input bit rr, input logic [7:0] d, input bit pe,
                                     input bit fa, input bit rst, output exp_t e);
        bit load = 1'b0;
        e.err = 5'b0;
        if (rst) begin
            m.active = 0; m.cnt = 0; m.acc = '0; m.idle = 0;
            m.held = 0; m.hdata = '0; m.hlen = 0;
        end else begin
            if (!m.active) begin
                if (rr && d == 8'h00 && !pe) begin
                    m.active = 1; m.cnt = 0; m.acc = '0; m.idle = 0;
                end
            end else if (rr) begin
                m.idle = 0;
                if (pe) begin
                    e.err[3] = 1; m.active = 0;
                end else if (d == 8'h00) begin
                    m.cnt = 0; m.acc = '0;
                end else if (d == 8'h0F) begin
                    m.active = 0;
                    if (m.cnt == 0 || (lx && m.cnt != n)) e.err[2] = 1;
                    else if (m.held && !fa)                e.err[0] = 1;
                    else                                   load = 1;
                end else if (int'(d[7:4]) == (m.cnt % 15) + 1) begin
                    if (m.cnt < n) begin
                        m.acc = m.acc * 16 + 160'(d[3:0]);
                        m.cnt++;
                    end else begin
                        e.err[2] = 1; m.active = 0;
                    end
                end else begin
                    e.err[4] = 1; m.active = 0;
                end
            end else if (to != 0) begin
                if (m.idle == to - 1) begin
                    e.err[1] = 1; m.active = 0;
                end else begin
                    m.idle++;
                end
            end
            if (load) begin
                m.held = 1; m.hdata = m.acc; m.hlen = m.cnt;
            end else if (m.held && fa) begin
                m.held = 0;
            end
        end
        e.rdy  = m.held;
        e.data = m.hdata;
        e.len  = m.hlen;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge for each instance.
    always @(posedge clk) begin
        exp_t ea, eb;
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("A.err",   160'(err_a),  160'(ea.err));
            chk("A.ready", 160'(rdy_a),  160'(ea.rdy));
            chk("A.data",  160'(data_a), ea.data);
            chk("A.len",   160'(len_a),  160'(ea.len));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("B.err",   160'(err_b),  160'(eb.err));
            chk("B.ready", 160'(rdy_b),  160'(eb.rdy));
            chk("B.data",  160'(data_b), eb.data);
            chk("B.len",   160'(len_b),  160'(eb.len));
        end
    end

    task automatic cycle(input bit rr, input logic [7:0] d, input bit pe, input bit rst);
        exp_t e;
        if (rand_fa) frame_accept = ($urandom_range(0, 3) == 0);
        reset = rst; rx_ready = rr; rx_data = d; rx_parity_error = pe;
        mdl_step(m_a, 4, 1'b0, 16, rr, d, pe, frame_accept, rst, e);
        q_a.push_back(e);
        mdl_step(m_b, 20, 1'b1, 0, rr, d, pe, frame_accept, rst, e);
        q_b.push_back(e);
        @(negedge clk);
    endtask

    task automatic sendb(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic take();
        frame_accept = 1'b1; idle(1); frame_accept = 1'b0;
    endtask

    task automatic gap();
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    endtask

    task automatic rand_frame();
        int n, bad, kind, tag;
        n    = $urandom_range(1, 22);
        kind = $urandom_range(0, 3);
        bad  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
        if (kind == 3 && bad >= 0) n = 0;
        if ($urandom_range(0, 9) == 0) sendb(8'($urandom));
        sendb(8'h00);
        for (int i = 0; i < n; i++) begin
            gap();
            tag = (i % 15) + 1;
            if (i == bad && kind == 0) tag = $urandom_range(0, 15);
            if (i == bad && kind == 2) idle(17);
            cycle(1'b1, {4'(tag), 4'($urandom)}, (i == bad && kind == 1), 1'b0);
        end
        gap();
        sendb(8'h0F);
    endtask

    initial begin
        frame_accept = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Basic frame, held with accept low, then consumed.
        sendb(8'h00); sendb(8'h1A); sendb(8'h2B); sendb(8'h3C); sendb(8'h4D); sendb(8'h0F);
        idle(10); take(); idle(2);

        // Twenty-nibble frame with tag wrap, then a short frame under exact length.
        sendb(8'h00);
        for (int t = 0; t < 20; t++) sendb({4'((t % 15) + 1), 4'(t % 16)});
        sendb(8'h0F); idle(2); take();
        sendb(8'h00); sendb(8'h1A); sendb(8'h2B); sendb(8'h0F); idle(2); take();

        // Sequence error, trailing bytes ignored, then a one-nibble frame.
        sendb(8'h00); sendb(8'h1A); sendb(8'h3B); sendb(8'h4C); sendb(8'h0F);
        sendb(8'h00); sendb(8'h15); sendb(8'h0F); idle(2); take();

        // Overflow while held, then accept coinciding with a new load.
        sendb(8'h00); sendb(8'h1A); sendb(8'h0F);
        sendb(8'h00); sendb(8'h17); sendb(8'h0F); idle(2);
        sendb(8'h00); sendb(8'h17); frame_accept = 1'b1; sendb(8'h0F); frame_accept = 1'b0;
        idle(2); take();

        // Timeout, then parity error.
        sendb(8'h00); sendb(8'h1A); idle(20);
        sendb(8'h00); sendb(8'h1A); cycle(1'b1, 8'h2B, 1'b1, 1'b0); idle(2);

        // Reset mid-frame with a frame held.
        sendb(8'h00); sendb(8'h1A); sendb(8'h0F);
        sendb(8'h00); sendb(8'h1A); sendb(8'h2B);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        sendb(8'h0F); idle(2);

        rand_fa = 1'b1;
        for (int f = 0; f < 200; f++) begin
            rand_frame();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            if ($urandom_range(0, 60) == 0) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        rand_fa = 1'b0;
        frame_accept = 1'b0;
        idle(3);
        @(posedge clk); #2;

        chk("A.queue_drained", 160'(q_a.size()), 160'(0));
        chk("B.queue_drained", 160'(q_b.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
